// File: rtl/ifd_pkg.sv
`default_nettype none
// ifd_pkg: shared limits and helpers for the ifd2_capture input stage.
package ifd_pkg;

  localparam int IFD_SYNC_MIN = 2;
  localparam int IFD_SYNC_MAX = 4;
  localparam int IFD_FILT_MAX = 15;

  // Counter width able to hold 0..filt_len.
  function automatic int cnt_width(input int filt_len);
    return (filt_len < 1) ? 1 : $clog2(filt_len + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifd_chan.sv
`default_nettype none
// ifd_chan: one capture channel -- synchronizer, glitch filter, level register,
// edge pulses and a sticky edge flag.
module ifd_chan
  import ifd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  input  logic clr,
  output logic q,
  output logic rise,
  output logic fall,
  output logic evt
);

  localparam int CW = cnt_width(FILT_LEN);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic          s;
  logic          hit;

  assign s   = sync[SYNC_STAGES-1];
  assign hit = (s != q) && (cnt == CW'(FILT_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
    end
  end

  // A new level must persist FILT_LEN cycles at s; any return restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      q    <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
      evt  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == q) begin
        cnt <= '0;
      end else if (hit) begin
        q    <= s;
        cnt  <= '0;
        rise <= s;
        fall <= ~s;
      end else begin
        cnt <= cnt + CW'(1);
      end

      if (hit) begin
        evt <= 1'b1;
      end else if (clr) begin
        evt <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ifd2_capture.sv
`default_nettype none
// ifd2_capture: two independent filtered input-capture channels with edge
// pulses and pollable sticky edge flags.
module ifd2_capture
  import ifd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic       CK,
  input  logic       RSTN,
  input  logic       D0,
  input  logic       D1,
  input  logic [1:0] CLR,
  output logic       Q0,
  output logic       Q1,
  output logic [1:0] RISE,
  output logic [1:0] FALL,
  output logic [1:0] EVT
);

  if (SYNC_STAGES < IFD_SYNC_MIN || SYNC_STAGES > IFD_SYNC_MAX) begin : g_bad_sync
    $error("ifd2_capture: SYNC_STAGES=%0d out of range", SYNC_STAGES);
  end
  if (FILT_LEN < 1 || FILT_LEN > IFD_FILT_MAX) begin : g_bad_filt
    $error("ifd2_capture: FILT_LEN=%0d out of range", FILT_LEN);
  end

  logic [1:0] d_bus;
  logic [1:0] q_bus;

  assign d_bus = {D1, D0};
  assign Q0    = q_bus[0];
  assign Q1    = q_bus[1];

  for (genvar n = 0; n < 2; n++) begin : g_chan
    ifd_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_LEN   (FILT_LEN)
    ) u_chan (
      .clk  (CK),
      .rst_n(RSTN),
      .d    (d_bus[n]),
      .clr  (CLR[n]),
      .q    (q_bus[n]),
      .rise (RISE[n]),
      .fall (FALL[n]),
      .evt  (EVT[n])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_ifd2_capture.sv
`default_nettype none
// tb_ifd2_capture: directed bench with an expected-edge scoreboard for a
// default instance and a FILT_LEN=1 / SYNC_STAGES=3 instance.
module tb_ifd2_capture;

  logic       ck;
  logic       rstn;
  logic       d0a, d1a, d0b, d1b;
  logic [1:0] clra, clrb;
  logic       q0a, q1a, q0b, q1b;
  logic [1:0] risea, falla, evta, riseb, fallb, evtb;

  typedef struct {
    int   dut;
    int   ch;
    logic rise;
    int   at;
  } ev_t;

  ev_t sb[$];
  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;

  ifd2_capture u_a (
    .CK(ck), .RSTN(rstn), .D0(d0a), .D1(d1a), .CLR(clra),
    .Q0(q0a), .Q1(q1a), .RISE(risea), .FALL(falla), .EVT(evta)
  );

  ifd2_capture #(.SYNC_STAGES(3), .FILT_LEN(1)) u_b (
    .CK(ck), .RSTN(rstn), .D0(d0b), .D1(d1b), .CLR(clrb),
    .Q0(q0b), .Q1(q1b), .RISE(riseb), .FALL(fallb), .EVT(evtb)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int dut, input int ch, input logic rise, input int at);
    ev_t e;
    e.dut  = dut;
    e.ch   = ch;
    e.rise = rise;
    e.at   = at;
    sb.push_back(e);
  endtask

  // Every cycle, each pulse output must equal what the scoreboard expects now.
  task automatic mon(input int dut, input logic [1:0] r, input logic [1:0] f);
    logic er, ef;
    for (int ch = 0; ch < 2; ch++) begin
      er = 1'b0;
      ef = 1'b0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].dut == dut && sb[i].ch == ch && sb[i].at == cyc) begin
          if (sb[i].rise) er = 1'b1;
          else            ef = 1'b1;
          sb.delete(i);
        end
      end
      chk($sformatf("rise d%0d ch%0d cyc%0d", dut, ch, cyc), r[ch], er);
      chk($sformatf("fall d%0d ch%0d cyc%0d", dut, ch, cyc), f[ch], ef);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
    cyc++;
    mon(0, risea, falla);
    mon(1, riseb, fallb);
  endtask

  initial begin
    rstn = 1'b0;
    d0a = 1'b0; d1a = 1'b0; d0b = 1'b0; d1b = 1'b0;
    clra = 2'b00; clrb = 2'b00;

    tick();
    tick();
    chk("rst_q0", q0a, 1'b0);
    chk("rst_q1", q1a, 1'b0);
    chk("rst_evt", evta, 2'b00);
    chk("rst_q0b", q0b, 1'b0);
    rstn = 1'b1;
    repeat (3) tick();

    // Clean rising level on channel 0
    d0a = 1'b1;
    push(0, 0, 1'b1, cyc + 5);
    repeat (4) tick();
    chk("t1_q0_early", q0a, 1'b0);
    tick();
    chk("t1_q0", q0a, 1'b1);
    chk("t1_evt", evta, 2'b01);
    tick();
    chk("t1_q1", q1a, 1'b0);

    // Two-cycle glitch on channel 1 is filtered out
    d1a = 1'b1;
    tick();
    tick();
    d1a = 1'b0;
    repeat (10) tick();
    chk("t2_q1", q1a, 1'b0);
    chk("t2_evt1", evta[1], 1'b0);

    // Toggling with a clear pulse between edges
    clra = 2'b01;
    tick();
    clra = 2'b00;
    chk("t3_evt_clr", evta[0], 1'b0);
    for (int i = 0; i < 3; i++) begin
      d0a = ~d0a;
      push(0, 0, d0a, cyc + 5);
      repeat (3) tick();
      clra = 2'b01;
      tick();
      clra = 2'b00;
      chk($sformatf("t3_evt_drop%0d", i), evta[0], 1'b0);
      tick();
      chk($sformatf("t3_evt_set%0d", i), evta[0], 1'b1);
      chk($sformatf("t3_q0_%0d", i), q0a, d0a);
      repeat (3) tick();
    end

    // Clear coincident with an edge: the set wins
    d0a = 1'b1;
    push(0, 0, 1'b1, cyc + 5);
    repeat (4) tick();
    clra = 2'b01;
    tick();
    clra = 2'b00;
    chk("t4_evt_setwins", evta[0], 1'b1);
    tick();
    chk("t4_evt_hold", evta[0], 1'b1);
    chk("t4_q0", q0a, 1'b1);

    // Reset mid-filter on channel 1
    d1a = 1'b1;
    repeat (4) tick();
    chk("t5_q0_pre", q0a, 1'b1);
    rstn = 1'b0;
    #1;
    chk("t5_q0_rst", q0a, 1'b0);
    chk("t5_q1_rst", q1a, 1'b0);
    chk("t5_evt_rst", evta, 2'b00);
    chk("t5_rise_rst", risea, 2'b00);
    chk("t5_fall_rst", falla, 2'b00);
    tick();
    rstn = 1'b1;
    push(0, 0, 1'b1, cyc + 5);
    push(0, 1, 1'b1, cyc + 5);
    repeat (4) tick();
    chk("t5_q1_early", q1a, 1'b0);
    tick();
    chk("t5_q1", q1a, 1'b1);
    chk("t5_q0", q0a, 1'b1);
    chk("t5_evt", evta, 2'b11);

    // Unfiltered instance: a one-cycle pulse passes through
    d0b = 1'b1;
    push(1, 0, 1'b1, cyc + 4);
    push(1, 0, 1'b0, cyc + 5);
    tick();
    d0b = 1'b0;
    tick();
    tick();
    chk("t6_q0b_early", q0b, 1'b0);
    tick();
    chk("t6_q0b_high", q0b, 1'b1);
    tick();
    chk("t6_q0b_low", q0b, 1'b0);
    chk("t6_evtb", evtb, 2'b01);
    repeat (3) tick();

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
